// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared across the MIPS core.
//   - Opcode constants for the primary opcode field instr[31:26].
//   - Extend-mode encodings, shared with the sign-extend unit in ID.
//   - The bubble instruction word, sll $0,$0,0, which is all zeros.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/ext_mode_decode.sv
// ext_mode_decode: combinational decoder from a 6-bit primary opcode to the
// 2-bit immediate extend mode.
//   opcode   : in,  6 - instr[31:26]
//   ext_mode : out, 2 - EXT_SIGN for arithmetic, compare, branch and memory
//                       immediates; EXT_ZERO for logical immediates, lui,
//                       R-type, J-type and undefined opcodes
module ext_mode_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [1:0] ext_mode
);

    always_comb begin
        ext_mode = EXT_ZERO;
        case (opcode)
            OP_BEQ, OP_BNE,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW:  ext_mode = EXT_SIGN;
            default:              ext_mode = EXT_ZERO;
        endcase
    end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register of the MIPS core.
// Captures the instruction and PC+4 from IF, holds them under stall, loads a
// bubble on flush or when IF has nothing valid, decodes the instruction
// fields, and registers the immediate extend mode alongside the instruction.
// A saturating counter records how many cycles the stage was stalled.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_instr, i_pc_plus4   : instruction word and PC+4 from IF
//   i_valid               : IF presents a real instruction
//   i_stall, i_flush      : hold request / squash request
//   o_ready               : !i_stall, IF advances only when high
//   o_valid, o_instr, o_pc_plus4 : held instruction state
//   o_opcode .. o_funct, o_imm   : field slices of o_instr
//   o_ext_mode            : extend mode for o_imm
//   o_stall_cnt           : saturating count of stalled cycles
module if_id_stage
    import mips_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [31:0]            i_instr,
    input  logic [31:0]            i_pc_plus4,
    input  logic                   i_valid,
    input  logic                   i_stall,
    input  logic                   i_flush,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [31:0]            o_instr,
    output logic [31:0]            o_pc_plus4,
    output logic [5:0]             o_opcode,
    output logic [4:0]             o_rs,
    output logic [4:0]             o_rt,
    output logic [4:0]             o_rd,
    output logic [4:0]             o_shamt,
    output logic [5:0]             o_funct,
    output logic [15:0]            o_imm,
    output logic [1:0]             o_ext_mode,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    logic [1:0]             ext_mode_p0;
    logic                   vld_p1;
    logic [31:0]            instr_p1;
    logic [31:0]            pc_plus4_p1;
    logic [1:0]             ext_mode_p1;
    logic [STALL_CNT_W-1:0] stall_cnt;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Decoding from the incoming opcode keeps the mode aligned with o_imm.
    ext_mode_decode u_ext_mode_decode (
        .opcode   (i_instr[31:26]),
        .ext_mode (ext_mode_p0)
    );

    // ---- IF -> ID boundary ----
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush || (!i_stall && !i_valid)) begin
            vld_p1      <= 1'b0;
            instr_p1    <= NOP_INSTR;
            pc_plus4_p1 <= 32'h0;
            ext_mode_p1 <= EXT_ZERO;
        end else if (!i_stall) begin
            vld_p1      <= 1'b1;
            instr_p1    <= i_instr;
            pc_plus4_p1 <= i_pc_plus4;
            ext_mode_p1 <= ext_mode_p0;
        end
    end

    // Counts stalled cycles even when a flush lands on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (i_stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign o_ready     = !i_stall;
    assign o_valid     = vld_p1;
    assign o_instr     = instr_p1;
    assign o_pc_plus4  = pc_plus4_p1;
    assign o_ext_mode  = ext_mode_p1;
    assign o_stall_cnt = stall_cnt;

    assign o_opcode = instr_p1[31:26];
    assign o_rs     = instr_p1[25:21];
    assign o_rt     = instr_p1[20:16];
    assign o_rd     = instr_p1[15:11];
    assign o_shamt  = instr_p1[10:6];
    assign o_funct  = instr_p1[5:0];
    assign o_imm    = instr_p1[15:0];

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed bench for if_id_stage. A default-width instance
// covers the datapath; a second instance with a 4-bit counter shares the same
// inputs and covers counter saturation.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        stall;
    logic        flush;

    logic        ready, o_valid;
    logic [31:0] o_instr, o_pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [1:0]  ext_mode;
    logic [15:0] stall_cnt;

    logic        s_ready, s_valid;
    logic [31:0] s_instr, s_pc_plus4;
    logic [5:0]  s_opcode, s_funct;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
    logic [15:0] s_imm;
    logic [1:0]  s_ext_mode;
    logic [3:0]  s_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_id_stage dut (
        .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_pc_plus4(pc_plus4),
        .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .o_ready(ready), .o_valid(o_valid), .o_instr(o_instr),
        .o_pc_plus4(o_pc_plus4), .o_opcode(opcode), .o_rs(rs), .o_rt(rt),
        .o_rd(rd), .o_shamt(shamt), .o_funct(funct), .o_imm(imm),
        .o_ext_mode(ext_mode), .o_stall_cnt(stall_cnt)
    );

    if_id_stage #(.STALL_CNT_W(4)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_pc_plus4(pc_plus4),
        .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .o_ready(s_ready), .o_valid(s_valid), .o_instr(s_instr),
        .o_pc_plus4(s_pc_plus4), .o_opcode(s_opcode), .o_rs(s_rs), .o_rt(s_rt),
        .o_rd(s_rd), .o_shamt(s_shamt), .o_funct(s_funct), .o_imm(s_imm),
        .o_ext_mode(s_ext_mode), .o_stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr = 32'h2008FFFF; pc_plus4 = 32'h0;
        valid = 1'b1; stall = 1'b0; flush = 1'b0;
        step(); step();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_instr", o_instr, 32'h0);
        check("rst_pc", o_pc_plus4, 32'h0);
        check("rst_ext", 32'(ext_mode), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);

        // addi $8,$8,-4
        rst = 1'b0; instr = 32'h2108FFFC; pc_plus4 = 32'h0000_0104;
        step();
        check("addi_valid", 32'(o_valid), 32'd1);
        check("addi_opcode", 32'(opcode), 32'h08);
        check("addi_rs", 32'(rs), 32'd8);
        check("addi_rt", 32'(rt), 32'd8);
        check("addi_imm", 32'(imm), 32'hFFFC);
        check("addi_ext", 32'(ext_mode), 32'd1);
        check("addi_pc", o_pc_plus4, 32'h104);

        instr = 32'h3508FFFF; pc_plus4 = 32'h108;   // ori
        step();
        check("ori_ext", 32'(ext_mode), 32'd0);
        check("ori_imm", 32'(imm), 32'hFFFF);

        instr = 32'h3C01ABCD; pc_plus4 = 32'h10C;   // lui $1,0xABCD
        step();
        check("lui_ext", 32'(ext_mode), 32'd0);
        check("lui_rt", 32'(rt), 32'd1);
        check("lui_imm", 32'(imm), 32'hABCD);

        instr = 32'h012A4020; pc_plus4 = 32'h110;   // add $8,$9,$10
        step();
        check("add_rs", 32'(rs), 32'd9);
        check("add_rt", 32'(rt), 32'd10);
        check("add_rd", 32'(rd), 32'd8);
        check("add_shamt", 32'(shamt), 32'd0);
        check("add_funct", 32'(funct), 32'h20);
        check("add_ext", 32'(ext_mode), 32'd0);

        instr = 32'h8D090010; pc_plus4 = 32'h114;   // lw $9,16($8)
        step();
        check("lw_ext", 32'(ext_mode), 32'd1);
        check("lw_instr", o_instr, 32'h8D090010);

        stall = 1'b1; instr = 32'h3508FFFF; pc_plus4 = 32'h118;
        #1;
        check("stall_ready", 32'(ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_instr", o_instr, 32'h8D090010);
            instr = 32'h1000_0000 + i;
        end
        check("stall_ext", 32'(ext_mode), 32'd1);
        check("stall_valid", 32'(o_valid), 32'd1);
        check("stall_pc", o_pc_plus4, 32'h114);
        check("stall_cnt", 32'(stall_cnt), 32'd3);

        flush = 1'b1;
        step();
        check("flush_instr", o_instr, 32'h0);
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_ext", 32'(ext_mode), 32'd0);
        check("flush_pc", o_pc_plus4, 32'h0);
        check("flush_cnt", 32'(stall_cnt), 32'd4);

        stall = 1'b0; flush = 1'b0; instr = 32'h10000003; pc_plus4 = 32'h200; // beq
        #1;
        check("release_ready", 32'(ready), 32'd1);
        step();
        check("beq_valid", 32'(o_valid), 32'd1);
        check("beq_ext", 32'(ext_mode), 32'd1);
        check("beq_cnt_hold", 32'(stall_cnt), 32'd4);

        valid = 1'b0; instr = 32'h8D090010;
        step();
        check("inval_valid", 32'(o_valid), 32'd0);
        check("inval_instr", o_instr, 32'h0);
        check("inval_ext", 32'(ext_mode), 32'd0);

        valid = 1'b1; instr = 32'h08000040;          // j
        step();
        check("j_ext", 32'(ext_mode), 32'd0);
        instr = 32'hFC000000;                         // undefined opcode 0x3F
        step();
        check("undef_ext", 32'(ext_mode), 32'd0);
        instr = 32'hAD090004;                         // sw
        step();
        check("sw_ext", 32'(ext_mode), 32'd1);

        // flush alone, no stall: bubble and counter unchanged
        flush = 1'b1; instr = 32'h2108FFFC;
        step();
        check("flush_only_valid", 32'(o_valid), 32'd0);
        check("flush_only_cnt", 32'(stall_cnt), 32'd4);
        flush = 1'b0;

        // reset during stall
        rst = 1'b1; stall = 1'b1;
        step();
        check("rst_stall_valid", 32'(o_valid), 32'd0);
        check("rst_stall_instr", o_instr, 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_stall_cnt4", 32'(s_stall_cnt), 32'd0);

        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("sat_cnt4", 32'(s_stall_cnt), 32'hF);
        check("sat_cnt16", 32'(stall_cnt), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register for the MIPS core. It captures the fetched instruction and PC+4 on each clock and holds them under stall. It inserts a bubble on flush, decodes the instruction fields, and produces the 16-bit immediate plus the 2-bit extend-mode control that feed the sign-extend unit in ID. It also keeps a saturating stall counter for performance observation.

## Interface
Parameters:
- STALL_CNT_W, default 16: width of the saturating stall counter.

Ports:
- i_clk, input, 1: the single clock; all state updates on its rising edge.
- i_rst, input, 1: synchronous reset, active-high.
- i_instr, input, 32: instruction word from IF.
- i_pc_plus4, input, 32: PC+4 from IF.
- i_valid, input, 1: IF presents a real instruction.
- i_stall, input, 1: hazard unit freezes this stage.
- i_flush, input, 1: branch/jump taken; squash the instruction held in this stage.
- o_ready, output, 1: equals !i_stall (combinational); IF advances only when it is 1.
- o_valid, output, 1: held instruction is real.
- o_instr, output, 32: held instruction.
- o_pc_plus4, output, 32: held PC+4.
- o_opcode, output, 6: o_instr[31:26].
- o_rs, output, 5: o_instr[25:21].
- o_rt, output, 5: o_instr[20:16].
- o_rd, output, 5: o_instr[15:11].
- o_shamt, output, 5: o_instr[10:6].
- o_funct, output, 6: o_instr[5:0].
- o_imm, output, 16: o_instr[15:0]; drives the sign-extend data input.
- o_ext_mode, output, 2: drives the sign-extend enable input. 2'd1 = sign-extend, 2'd0 = zero-extend; 2'd2 and 2'd3 are never produced.
- o_stall_cnt, output, STALL_CNT_W: number of cycles with i_stall=1 since reset; saturates at all-ones.

## Operation
Per-cycle priority at the rising edge is i_rst, then i_flush, then i_stall, then load:
- **Reset:** o_instr=0, o_pc_plus4=0, o_valid=0, o_ext_mode=0, o_stall_cnt=0.
- **Flush:** load a bubble: o_instr=32'h0000_0000 (sll $0,$0,0 NOP), o_pc_plus4=0, o_valid=0, o_ext_mode=0. Flush overrides a simultaneous stall.
- **Stall (no flush):** every register holds its value.
- **Load:**
  - If i_valid=1: capture i_instr and i_pc_plus4, set o_valid=1, and register the ext_mode decoded from i_instr[31:26].
  - If i_valid=0: load a bubble as for flush.
- **Extend-mode decode** (from the incoming opcode, registered together with the instruction):
  - Opcode 0x04 beq, 0x05 bne, 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu, 0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2B sw gives 2'd1.
  - Opcode 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui gives 2'd0.
  - R-type (0x00), J-type (0x02, 0x03) and undefined opcodes give 2'd0.
- **Stall counter:**
  - Increments by 1 on every non-reset cycle with i_stall=1, including cycles where flush also applies.
  - Holds once it reaches all-ones.
- **Field outputs:** pure slices of o_instr, with no extra register.

## Timing
- Latency is 1 cycle: an input presented at edge N, with no stall and no flush, appears on all outputs after edge N.
- o_ext_mode is registered, so it is aligned with o_imm in the same cycle. The sign extender downstream is combinational, so the extended value is ready within ID.
- Reset mid-stall: reset wins and all outputs take their reset values on that edge. The counter also clears.
- Flush and stall on the same edge: a bubble is loaded and the counter still increments.
- Stall released: the next edge loads whatever IF presents at that edge. IF must hold its outputs while o_ready=0.
- o_ready is combinational from i_stall, with no other input in the path.

## Structure
Shared package mips_pkg holds:
- opcode localparams (OP_RTYPE, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW, ...);
- EXT_ZERO=2'd0 and EXT_SIGN=2'd1, which the sign-extend unit also uses;
- NOP_INSTR=32'h0.

One sub-module is natural: ext_mode_decode, a combinational 6-bit opcode to 2-bit mode decoder. It is instantiated on the i_instr path and is reusable by the main control unit.

## Test plan
- **Reset:** hold i_rst=1 for 2 cycles with i_instr=32'h2008FFFF, i_valid=1 -> o_valid=0, o_instr=0, o_ext_mode=0, o_stall_cnt=0.
- **Sign-extend load:** load i_instr=32'h2108FFFC (addi $8,$8,-4), i_pc_plus4=32'h0000_0104 -> after 1 edge: o_valid=1, o_rs=8, o_rt=8, o_imm=16'hFFFC, o_ext_mode=1, o_pc_plus4=32'h104.
- **Zero-extend load:** load i_instr=32'h3508FFFF (ori) -> o_ext_mode=0, o_imm=16'hFFFF. Then load lui 32'h3C01ABCD -> o_ext_mode=0.
- **Stall:** after loading lw 32'h8D090010, hold i_stall=1 for 3 cycles while i_instr changes -> o_instr stays 32'h8D090010, o_ext_mode=1, o_ready=0, o_stall_cnt=3.
- **Flush during stall:** i_stall=1 and i_flush=1 together -> next cycle o_instr=0, o_valid=0, o_ext_mode=0, and o_stall_cnt increments.
- **Counter saturation:** with STALL_CNT_W=4, hold i_stall=1 for 20 cycles -> o_stall_cnt=4'hF, with no wrap to 0.
